// File: rtl/zc_spi_pkg.sv
// Shared types and constants for the Z-Controller SPI master.
// Imported by the clock generator and the top-level FSM.
package zc_spi_pkg;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  localparam int CFG_CS_BIT    = 1;
  localparam int BITS_PER_XFER = 8;

endpackage

// File: rtl/zc_spi_clkgen.sv
// SCK half-period divider advancing on ce only.
// Emits single-clk rise/fall strobes aligned with the registered SCK edge.
module zc_spi_clkgen
  import zc_spi_pkg::*;
#(
  parameter int DIV_HALF = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ce,
  input  logic i_en,
  input  logic i_clr,
  output logic o_rise,
  output logic o_fall,
  output logic o_sck
);

  localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sck;
  logic          w_tick;

  assign w_tick = i_en & i_ce & ~i_clr & (r_cnt == LAST);
  assign o_rise = w_tick & ~r_sck;
  assign o_fall = w_tick & r_sck;
  assign o_sck  = r_sck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (i_en && i_ce) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/zc_spi_master.sv
// Z-Controller SPI master: CPU data/config ports to SPI mode-0 bytes.
// busy stalls the CPU until the received byte is in dout.
module zc_spi_master
  import zc_spi_pkg::*;
#(
  parameter int         DIV_HALF = 1,
  parameter logic [7:0] IDLE_TX  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cfg_wr,
  input  logic       data_wr,
  input  logic       data_rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       sd_cs_n
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_dout;
  logic [2:0] r_bit;
  logic       r_mosi;
  logic       r_cs_n;

  logic       w_start;
  logic       w_rise;
  logic       w_fall;
  logic       w_last;
  logic       w_shift;
  logic [7:0] w_load;

  assign w_shift = (r_state == S_SHIFT);
  assign w_start = ~w_shift & (data_wr | data_rd);
  assign w_load  = data_wr ? din : IDLE_TX;
  assign w_last  = w_fall & (r_bit == 3'(BITS_PER_XFER - 1));

  zc_spi_clkgen #(
    .DIV_HALF (DIV_HALF)
  ) u_clkgen (
    .clk    (clk),
    .reset  (reset),
    .i_ce   (ce),
    .i_en   (w_shift),
    .i_clr  (w_start),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_sck  (sd_clk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_SHIFT;
      S_SHIFT: if (w_last)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= 8'hFF;
      r_rx   <= 8'h00;
      r_dout <= 8'hFF;
      r_bit  <= 3'd0;
      r_mosi <= 1'b1;
      r_cs_n <= 1'b1;
    end else begin
      // Chip select follows the config port even mid-transfer.
      if (cfg_wr) r_cs_n <= din[CFG_CS_BIT];
      if (w_start) begin
        r_tx   <= w_load;
        r_mosi <= w_load[7];
        r_bit  <= 3'd0;
      end else if (w_shift) begin
        if (w_rise) r_rx <= {r_rx[6:0], sd_miso};
        if (w_last) begin
          r_dout <= r_rx;
          r_mosi <= 1'b1;
          r_bit  <= 3'd0;
        end else if (w_fall) begin
          r_tx   <= {r_tx[6:0], 1'b1};
          r_mosi <= r_tx[6];
          r_bit  <= r_bit + 3'd1;
        end
      end
    end
  end

  assign dout    = r_dout;
  assign busy    = w_shift;
  assign sd_mosi = r_mosi;
  assign sd_cs_n = r_cs_n;

endmodule

// File: tb/tb_zc_spi_master.sv
// Scoreboard bench for zc_spi_master with a mode-0 slave model.
// Directed transfers push expectations; a negedge monitor checks completions.
module tb_zc_spi_master;

  localparam int DH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       cfg_wr = 1'b0;
  logic       data_wr = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       busy;
  logic       sd_clk;
  logic       sd_mosi;
  logic       sd_miso;
  logic       sd_cs_n;

  zc_spi_master #(
    .DIV_HALF (DH),
    .IDLE_TX  (8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .cfg_wr  (cfg_wr),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .din     (din),
    .dout    (dout),
    .busy    (busy),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso),
    .sd_cs_n (sd_cs_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] slv_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ce pattern: 0 = held low, N = one tick every N clocks
  int ce_div = 1;
  int ce_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (ce_div == 0) begin
      ce = 1'b0;
    end else begin
      ce = (ce_cnt == 0);
      ce_cnt = (ce_cnt + 1) % ce_div;
    end
  end

  logic       prev_busy = 1'b0;
  logic       prev_sck = 1'b0;
  logic [7:0] slv = 8'hFF;
  logic [7:0] mcap = 8'h00;
  logic [3:0] rcnt = 4'd8;
  int         ticks = 0;
  exp_t       e;

  assign sd_miso = (rcnt < 4'd8) ? slv[3'd7 - rcnt[2:0]] : 1'b1;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      rcnt = 4'd0;
      mcap = 8'h00;
      ticks = 0;
      if (slv_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL slave_queue: got empty expected a byte");
      end else begin
        slv = slv_q.pop_front();
      end
    end
    if (busy && sd_clk && !prev_sck) begin
      mcap = {mcap[6:0], sd_mosi};
      rcnt = rcnt + 4'd1;
    end
    if (busy && ce) ticks++;
    if (!busy && prev_busy && !reset) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got completion expected none");
      end else begin
        e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(e.rx));
        chk("mosi_byte", 32'(mcap), 32'(e.tx));
        chk("sck_rises", 32'(rcnt), 32'd8);
        chk("ce_ticks", 32'(ticks), 32'(16 * DH));
        chk("sck_idle", 32'(sd_clk), 32'd0);
        chk("mosi_idle", 32'(sd_mosi), 32'd1);
      end
    end
    prev_busy = busy;
    prev_sck = sd_clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic wr, input logic rd, input logic [7:0] d);
    data_wr = wr;
    data_rd = rd;
    din = d;
    tick(1);
    data_wr = 1'b0;
    data_rd = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] d);
    cfg_wr = 1'b1;
    din = d;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic push(input logic [7:0] tx, input logic [7:0] rx);
    exp_t x;
    x.tx = tx;
    x.rx = rx;
    exp_q.push_back(x);
    slv_q.push_back(rx);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic held;
    int   r;
    logic p;

    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_cs_n", 32'(sd_cs_n), 32'd1);
    chk("rst_sck", 32'(sd_clk), 32'd0);
    chk("rst_mosi", 32'(sd_mosi), 32'd1);
    chk("rst_dout", 32'(dout), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);

    cfg(8'h00);
    chk("cs_low", 32'(sd_cs_n), 32'd0);
    push(8'hA5, 8'h3C);
    xfer(1'b1, 1'b0, 8'hA5);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_mosi", 32'(sd_mosi), 32'd1);
    wait_idle("t2_idle", 200);
    chk("t2_cs_n", 32'(sd_cs_n), 32'd0);
    tick(2);

    push(8'hFF, 8'h81);
    xfer(1'b0, 1'b1, 8'h55);
    r = 0;
    while (busy && r < 200) begin
      tick(1);
      r++;
    end
    chk("t3_first_done", 32'(busy), 32'd0);
    push(8'h00, 8'h5A);
    xfer(1'b1, 1'b0, 8'h00);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_dout_hold0", 32'(dout), 32'h81);
    tick(10);
    chk("b2b_dout_hold1", 32'(dout), 32'h81);
    wait_idle("t3_idle", 200);
    tick(2);

    ce_div = 3;
    push(8'hC3, 8'h11);
    xfer(1'b1, 1'b0, 8'hC3);
    tick(5);
    xfer(1'b1, 1'b0, 8'h77);
    wait_idle("t4_idle", 500);
    tick(4);
    chk("ignored_strobe", 32'(busy), 32'd0);
    push(8'h96, 8'h22);
    xfer(1'b1, 1'b1, 8'h96);
    wait_idle("t4b_idle", 500);
    ce_div = 1;
    tick(2);

    push(8'hE7, 8'h0F);
    xfer(1'b1, 1'b0, 8'hE7);
    tick(6);
    cfg(8'h02);
    chk("cfg_mid_cs_n", 32'(sd_cs_n), 32'd1);
    ce_div = 0;
    tick(2);
    held = sd_clk;
    tick(8);
    chk("freeze_sck", 32'(sd_clk), 32'(held));
    chk("freeze_busy", 32'(busy), 32'd1);
    ce_div = 1;
    wait_idle("t6_idle", 200);
    tick(2);

    slv_q.push_back(8'h99);
    xfer(1'b1, 1'b0, 8'h5A);
    r = 0;
    p = sd_clk;
    for (int k = 0; k < 100 && r < 3; k++) begin
      tick(1);
      if (sd_clk && !p) r++;
      p = sd_clk;
    end
    chk("third_rise", 32'(r), 32'd3);
    reset = 1'b1;
    tick(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sck", 32'(sd_clk), 32'd0);
    chk("abort_mosi", 32'(sd_mosi), 32'd1);
    chk("abort_cs_n", 32'(sd_cs_n), 32'd1);
    chk("abort_dout", 32'(dout), 32'hFF);
    tick(1);
    reset = 1'b0;
    tick(2);

    cfg(8'h00);
    push(8'h12, 8'hC7);
    xfer(1'b1, 1'b0, 8'h12);
    wait_idle("recover_idle", 200);
    tick(5);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
